// File: rtl/wb_dual.sv
// Write-back stage for a dual-issue pipeline: commits both slots to RF/HILO and
// serializes the commit trace when WB_TRACE_SERIAL_EN is defined.
module wb_dual (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [5:0]   stall,
    input  logic [271:0] mem_to_wb_bus,
    output logic [207:0] wb_to_rf_bus,
    output logic         stallreq_for_wb,
    output logic [31:0]  debug_wb_pc,
    output logic [3:0]   debug_wb_rf_wen,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [31:0]  debug_wb_rf_wdata
);

    localparam int unsigned SlotW   = 136;
    localparam int unsigned RfSlotW = 104;
    localparam int unsigned WbStage = 5;

`ifdef WB_TRACE_SERIAL_EN
    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
`else
    typedef enum logic {IDLE, EMIT1} state_t;
`endif

    state_t               state;
    state_t               state_n;
    logic [271:0]         wb_r;
    logic [SlotW-1:0]     slot1;
    logic [SlotW-1:0]     slot2;
    logic                 valid1;
    logic                 valid2;
    logic [RfSlotW-1:0]   rf1;
    logic [RfSlotW-1:0]   rf2;
    logic                 stallreq;
    logic                 capture;
    logic                 load_valid;
    logic [SlotW-1:0]     trace_slot;
    logic                 unused_stall;

    assign slot1  = wb_r[135:0];
    assign slot2  = wb_r[271:136];
    assign valid1 = (slot1[69:38] != 32'd0);
    assign valid2 = (slot2[69:38] != 32'd0);

    // RF payload drops the pc; invalid slots are carried as zero
    assign rf1 = valid1 ? {slot1[135:70], slot1[37:0]} : RfSlotW'(0);
    assign rf2 = valid2 ? {slot2[135:70], slot2[37:0]} : RfSlotW'(0);

`ifdef WB_TRACE_SERIAL_EN
    assign stallreq = (state == EMIT1) && valid1 && valid2;
`else
    assign stallreq = 1'b0;
`endif

    assign capture    = !stall[WbStage] && !stallreq;
    assign load_valid = !flush && ((mem_to_wb_bus[69:38] != 32'd0) ||
                                   (mem_to_wb_bus[205:174] != 32'd0));
    assign unused_stall = ^stall[4:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wb_r  <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                wb_r <= flush ? 272'(0) : mem_to_wb_bus;
            end
        end
    end

    // Next-state, RF bus and trace slot selection
    always_comb begin
        state_n      = IDLE;
        wb_to_rf_bus = '0;
        trace_slot   = '0;

        if (stallreq) begin
`ifdef WB_TRACE_SERIAL_EN
            state_n = EMIT2;
`endif
        end else if (capture && load_valid) begin
            state_n = EMIT1;
        end

        case (state)
            EMIT1: begin
                wb_to_rf_bus = {rf2, rf1};
`ifdef WB_TRACE_SERIAL_EN
                trace_slot   = valid1 ? slot1 : slot2;
`else
                trace_slot   = valid1 ? slot1 : SlotW'(0);
`endif
            end
`ifdef WB_TRACE_SERIAL_EN
            EMIT2: begin
                trace_slot = slot2;
            end
`endif
            default: ;
        endcase
    end

    assign stallreq_for_wb   = stallreq;
    assign debug_wb_pc       = trace_slot[69:38];
    assign debug_wb_rf_wen   = {4{trace_slot[37]}};
    assign debug_wb_rf_wnum  = trace_slot[36:32];
    assign debug_wb_rf_wdata = trace_slot[31:0];

endmodule

// File: tb/tb_wb_dual.sv
// Self-checking bench for wb_dual: per-cycle expected outputs are queued by each
// scenario and popped one cycle after each driven edge.
module tb_wb_dual;

`ifdef WB_TRACE_SERIAL_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0]  pc;
        logic [3:0]   wen;
        logic [4:0]   wnum;
        logic [31:0]  wdata;
        logic         sr;
        logic [207:0] rf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [5:0]   stall;
    logic [271:0] mem_to_wb_bus;
    logic [207:0] wb_to_rf_bus;
    logic         stallreq_for_wb;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    exp_t q[$];
    int   n_checks;
    int   n_fail;

    logic [135:0] s1, s2, sa, sb, sc, snw, junk;

    wb_dual dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stall             (stall),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .wb_to_rf_bus      (wb_to_rf_bus),
        .stallreq_for_wb   (stallreq_for_wb),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [135:0] mk_slot(input logic [65:0] hilo, input logic [31:0] pc,
                                             input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
        return {hilo, pc, we, wa, wd};
    endfunction

    function automatic logic [103:0] rf_of(input logic [135:0] s);
        return {s[135:70], s[37], s[36:32], s[31:0]};
    endfunction

    function automatic exp_t tr(input logic [135:0] s, input logic sr, input logic [207:0] rf);
        exp_t e;
        e.pc    = s[69:38];
        e.wen   = {4{s[37]}};
        e.wnum  = s[36:32];
        e.wdata = s[31:0];
        e.sr    = sr;
        e.rf    = rf;
        return e;
    endfunction

    task automatic check_now(input string name);
        exp_t e;
        exp_t o;
        n_checks++;
        o = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
             stallreq_for_wb, wb_to_rf_bus};
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got pc=%h", name, o.pc);
        end else begin
            e = q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got pc=%h wen=%h wnum=%0d wdata=%h sr=%b rf=%h ; need pc=%h wen=%h wnum=%0d wdata=%h sr=%b rf=%h",
                         name, o.pc, o.wen, o.wnum, o.wdata, o.sr, o.rf,
                         e.pc, e.wen, e.wnum, e.wdata, e.sr, e.rf);
            end
        end
    endtask

    task automatic check_wb_r(input string name, input logic [271:0] want);
        n_checks++;
        if (dut.wb_r !== want) begin
            n_fail++;
            $display("FAIL %s: got wb_r=%h need %h", name, dut.wb_r, want);
        end
    endtask

    task automatic step(input logic [271:0] bus, input logic fl, input logic st, input string name);
        mem_to_wb_bus = bus;
        flush         = fl;
        stall         = {st, 5'b01011};
        @(posedge clk);
        #1;
        check_now(name);
    endtask

    task automatic async_reset(input string name);
        #2;
        rst = 1'b1;
        #1;
        q.push_back('0);
        check_now(name);
        check_wb_r({name, "_wb_r"}, 272'h0);
        n_checks++;
        if (dut.state !== '0) begin
            n_fail++;
            $display("FAIL %s_state: got %0d need 0 (IDLE)", name, dut.state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        q.push_back('0);
        check_now("reset_hold");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.push_back(tr(sa, 1'b0, {104'h0, rf_of(sa)}));
        step({136'h0, sa}, 1'b0, 1'b0, "reset_pre");
        async_reset("reset_async");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "reset_post_idle");
        q.push_back(tr(sa, 1'b0, {104'h0, rf_of(sa)}));
        step({136'h0, sa}, 1'b0, 1'b0, "reset_recover");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "reset_recover_idle");
    endtask

    task automatic test_single();
        q.push_back(tr(sa, 1'b0, {104'h0, rf_of(sa)}));
        step({136'h0, sa}, 1'b0, 1'b0, "single_issue");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "single_idle");
    endtask

    task automatic test_dual();
        q.push_back(tr(s1, SERIAL, {rf_of(s2), rf_of(s1)}));
        step({s2, s1}, 1'b0, 1'b0, "dual_cycle1");
        q.push_back(SERIAL ? tr(s2, 1'b0, 208'h0) : exp_t'(0));
        step(272'h0, 1'b0, 1'b0, "dual_cycle2");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "dual_idle");
        q.push_back(SERIAL ? tr(s2, 1'b0, {rf_of(s2), 104'h0})
                           : tr(136'h0, 1'b0, {rf_of(s2), 104'h0}));
        step({s2, 136'h0}, 1'b0, 1'b0, "slot2_only");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "slot2_only_idle");
    endtask

    task automatic test_no_we();
        q.push_back(tr(snw, 1'b0, {104'h0, rf_of(snw)}));
        step({junk, snw}, 1'b0, 1'b0, "no_we_traced");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "no_we_idle");
    endtask

    task automatic test_stall();
        q.push_back(tr(sa, 1'b0, {104'h0, rf_of(sa)}));
        step({136'h0, sa}, 1'b0, 1'b0, "stall_capture");
        for (int i = 0; i < 3; i++) begin
            q.push_back('0);
            step({136'h0, sb}, 1'b0, 1'b1, $sformatf("stall_hold%0d", i));
        end
        check_wb_r("stall_wb_r", {136'h0, sa});
        q.push_back(tr(sb, 1'b0, {104'h0, rf_of(sb)}));
        step({136'h0, sb}, 1'b0, 1'b0, "stall_release");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "stall_idle");
    endtask

    task automatic test_flush();
        q.push_back('0);
        step({s2, sa}, 1'b1, 1'b0, "flush_capture");
        check_wb_r("flush_wb_r", 272'h0);
        q.push_back(tr(s1, SERIAL, {rf_of(s2), rf_of(s1)}));
        step({s2, s1}, 1'b0, 1'b0, "flush_e1_cycle1");
        q.push_back(SERIAL ? tr(s2, 1'b0, 208'h0) : exp_t'(0));
        step({136'h0, sa}, 1'b1, 1'b0, "flush_e1_ignored");
        check_wb_r("flush_e1_wb_r", SERIAL ? {s2, s1} : 272'h0);
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "flush_e1_idle");
    endtask

    task automatic test_back_to_back();
        q.push_back(tr(sa, 1'b0, {104'h0, rf_of(sa)}));
        step({136'h0, sa}, 1'b0, 1'b0, "b2b_a");
        q.push_back(tr(sb, 1'b0, {104'h0, rf_of(sb)}));
        step({136'h0, sb}, 1'b0, 1'b0, "b2b_b");
        q.push_back(tr(s1, SERIAL, {rf_of(s2), rf_of(s1)}));
        step({s2, s1}, 1'b0, 1'b0, "b2b_dual");
        q.push_back(SERIAL ? tr(s2, 1'b0, 208'h0) : tr(sc, 1'b0, {104'h0, rf_of(sc)}));
        step({136'h0, sc}, 1'b0, 1'b0, "b2b_dual_next");
        q.push_back(tr(sc, 1'b0, {104'h0, rf_of(sc)}));
        step({136'h0, sc}, 1'b0, 1'b0, "b2b_c");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "b2b_idle");
    endtask

    task automatic test_reset_mid_emit();
        q.push_back(tr(s1, SERIAL, {rf_of(s2), rf_of(s1)}));
        step({s2, s1}, 1'b0, 1'b0, "rst_emit1_cycle1");
        async_reset("rst_emit1_async");
        q.push_back('0);
        step(272'h0, 1'b0, 1'b0, "rst_emit1_drop_slot2");
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        stall         = 6'h0;
        mem_to_wb_bus = '0;

        sa   = mk_slot(66'h0, 32'hBFC00010, 1'b1, 5'd5, 32'h0000_1234);
        sb   = mk_slot(66'h2_1111_2222_3333_4444, 32'hBFC00014, 1'b1, 5'd9, 32'hCAFE_0001);
        sc   = mk_slot(66'h1_0000_0000_0000_00FF, 32'hBFC00040, 1'b1, 5'd31, 32'h8000_0001);
        s1   = mk_slot(66'h0, 32'hBFC00020, 1'b1, 5'd3, 32'h0000_000A);
        s2   = mk_slot(66'h3_0000_0000_DEAD_BEEF, 32'hBFC00024, 1'b1, 5'd3, 32'h0000_000B);
        snw  = mk_slot(66'h0_0000_0000_0000_0005, 32'hBFC00030, 1'b0, 5'd7, 32'h0000_0077);
        junk = mk_slot(66'h3_FFFF_0000_FFFF_0000, 32'h0, 1'b1, 5'd9, 32'h5555_AAAA);

        test_reset();
        test_single();
        test_dual();
        test_no_we();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_emit();

        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_dual.md
WB_DUAL -- requirements
Module: wb_dual

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk (posedge) and rst.
REQ-002 SHALL have port `clk  in  1`: pipeline clock.
REQ-003 SHALL have port `rst  in  1`: async active-high reset.
REQ-004 SHALL have port `flush  in  1`: exception flush from CP0 control.
REQ-005 SHALL have port `stall  in  StallBus`: stage stall vector; bit 5 = WB stage.
REQ-006 SHALL have port `mem_to_wb_bus  in  272`: slot2 in 271:136, slot1 in 135:0.
  - Per-slot layout: hilo 135:70, pc 69:38, rf_we 37, rf_waddr 36:32, rf_wdata 31:0.
  - An all-zero slot is invalid.
REQ-007 SHALL have port `wb_to_rf_bus  out  208`, fields in this order: {hilo_i2, we_i2, waddr_i2, wdata_i2, hilo_i1, we_i1, waddr_i1, wdata_i1}.
REQ-008 SHALL have port `stallreq_for_wb  out  1`: request to freeze the pipeline for one cycle.
REQ-009 SHALL have ports `debug_wb_pc  out  32`, `debug_wb_rf_wen  out  4`, `debug_wb_rf_wnum  out  5`, `debug_wb_rf_wdata  out  32`: commit trace, one instruction per cycle.

Function
REQ-010 SHALL hold a 272-bit register wb_r and FSM states IDLE, EMIT1, EMIT2.
REQ-011 SHALL define a capture edge as a posedge where stall[5]==NoStop and stallreq_for_wb==0.
REQ-012 On a capture edge, wb_r SHALL load 0 if flush=1, else mem_to_wb_bus.
REQ-013 Otherwise wb_r SHALL hold its value.
REQ-014 Slot valid SHALL be defined as slot pc != 0.
REQ-015 After a capture edge the state SHALL be EMIT1 if any loaded slot is valid, else IDLE.
REQ-016 In EMIT1 with both slots valid:
  - stallreq_for_wb=1 (driven from registered state only, no combinational path from inputs);
  - next state EMIT2;
  - no capture occurs, and flush is ignored on that edge.
REQ-017 EMIT2 SHALL last exactly one cycle:
  - stallreq_for_wb=0;
  - next state from the next capture edge, else IDLE.
REQ-018 Trace selection SHALL be:
  - EMIT1 shows slot1 if valid, else slot2;
  - EMIT2 shows slot2;
  - IDLE shows all zeros.
REQ-019 Trace fields SHALL be: debug_wb_pc = slot pc; debug_wb_rf_wen = {4{slot rf_we}}; wnum/wdata = slot waddr/wdata.
REQ-020 wb_to_rf_bus SHALL carry invalid slots as zero.
REQ-021 wb_to_rf_bus SHALL be driven from wb_r only in EMIT1 and be all-zero in IDLE and EMIT2, so each commit writes the RF/HILO exactly once.
REQ-022 When both slots write the same register, ordering SHALL be resolved by the RF (slot2 priority); this block SHALL NOT merge writes.
REQ-023 Latency SHALL be one cycle from capture edge to RF write and first trace.
REQ-024 For dual-valid pairs, the second trace SHALL come one cycle later.
REQ-025 A slot with rf_we=0 SHALL still be traced, with pc shown and wen=0.

Reset
REQ-026 rst SHALL asynchronously set wb_r=0, state=IDLE, and all outputs 0.
REQ-027 rst asserted mid-EMIT1/EMIT2 SHALL drop the pending slot2 trace.
REQ-028 After rst deasserts, the first capture edge SHALL behave normally.

Configuration
REQ-029 SHALL provide the macro WB_TRACE_SERIAL_EN.
REQ-030 With WB_TRACE_SERIAL_EN defined: the serializer SHALL operate as specified in REQ-016..REQ-018.
REQ-031 With WB_TRACE_SERIAL_EN undefined:
  - no EMIT2 state;
  - stallreq_for_wb tied 0;
  - trace shows slot1 only (slot2 not traced);
  - RF bus behaviour unchanged.

Verification
REQ-032 Reset test: rst pulse mid-cycle with wb_r nonzero -> all outputs 0 immediately, state IDLE.
REQ-033 Single issue: slot1 = {pc=0xBFC00010, we=1, waddr=5, wdata=0x1234}, slot2=0 ->
  - next cycle trace pc=0xBFC00010, wen=4'hF, wnum=5, wdata=0x1234;
  - stallreq=0.
REQ-034 Dual issue: slot1 pc=0xBFC00020 (r3←0xA), slot2 pc=0xBFC00024 (r3←0xB) ->
  - cycle1: trace 0xBFC00020, stallreq=1, RF bus both slots;
  - cycle2: trace 0xBFC00024, RF bus 0, stallreq=0.
REQ-035 Stall hold: stall[5]=Stop for 3 cycles after a single-issue capture ->
  - trace emitted once, then zeros;
  - wb_r unchanged;
  - new bus value ignored until stall releases.
REQ-036 Flush: flush=1 on a capture edge with a valid bus -> wb_r=0, trace zero, no RF write.
REQ-037 Flush during EMIT1 of a dual pair -> ignored; slot2 still traced in EMIT2.
